// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;
    localparam int              PC_W             = 32;
    localparam logic [PC_W-1:0] INST_BYTES       = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~(INST_BYTES - 32'd1);
    endfunction
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory request/response and decode handshake bundle
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [PC_W-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [PC_W-1:0] PC;
    logic [PC_W-1:0] instruction;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, PC, instruction,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, PC, instruction,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry {pc, inst} buffer; flush overrides push and pop
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int ENT_W = 2 * PC_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [ENT_W-1:0] data_i,
    output logic [CNT_W-1:0] count_o,
    output logic [ENT_W-1:0] head_o
);
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

    // Issue throttling upstream must make a push into a full buffer impossible.
    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, in-order imem requests and redirect/drain control
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2,
    localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] target_PC,
    fetch_if.master         bus
);
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]  count;
    logic [2*PC_W-1:0] head;
    logic [CNT_W:0]    inflight;
    logic              inst_valid, pop, rsp, req_valid, accept, push;

    assign inst_valid = !reset && (count != '0);
    assign pop        = inst_valid && bus.inst_ready;
    assign rsp        = bus.imem_rsp_valid;
    // Counting the same-cycle pop lets issue continue at full rate with a 1-cycle memory.
    assign inflight   = {1'b0, outstanding_q} + {1'b0, count} - (CNT_W + 1)'(pop);
    assign req_valid  = !reset && (state_q == RUN) && !branch_taken && (inflight < DEPTH_W);
    assign accept     = req_valid && bus.imem_req_ready;
    assign push       = rsp && (state_q == RUN) && !branch_taken;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = inst_valid;
    assign bus.PC             = reset ? '0 : head[2*PC_W-1:PC_W];
    assign bus.instruction    = reset ? '0 : head[PC_W-1:0];

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_taken),
        .data_i  ({rsp_pc_q, bus.imem_rsp_data}),
        .count_o (count),
        .head_o  (head)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);
        if (accept) fetch_pc_d = fetch_pc_q + INST_BYTES;
        if (push)   rsp_pc_d   = rsp_pc_q + INST_BYTES;
        if ((state_q == DRAIN) && rsp) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        // A response arriving with the redirect is already gone, so it is not counted.
        if (branch_taken) begin
            fetch_pc_d = word_align(target_PC);
            rsp_pc_d   = word_align(target_PC);
            drop_cnt_d = outstanding_q - CNT_W'(rsp);
        end
        state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    rsp_without_req_a: assert property (@(posedge clock) disable iff (reset)
        rsp |-> (outstanding_q != '0));
endmodule
